// File: rtl/flappy_pkg.sv
// Shared constants and types for the flappy game logic on the 160x120 playfield.
// Score encoding depends on the SCORE_BCD_EN macro (BCD when defined, binary otherwise).
// Pure declarations; no state.
package flappy_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   localparam logic [2:0] GREEN = 3'b010;
   localparam logic [2:0] BLACK = 3'b000;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DEAD
   } game_state_t;

   // Game tuning
   localparam logic [7:0]        BIRD_X      = 8'd4;
   localparam logic signed [4:0] GRAVITY     = 5'sd1;
   localparam logic signed [4:0] FLAP_VEL    = 5'sd4;
   localparam logic signed [4:0] MAX_VEL     = 5'sd6;
   localparam logic [7:0]        PIPE_SPEED  = 8'd1;
   localparam logic [6:0]        GAP_H       = 7'd24;
   localparam logic [7:0]        GAP_MIN     = 8'd8;
   localparam logic [7:0]        GAP_MAX     = 8'd88;
   localparam logic [7:0]        GAP_SPAN    = GAP_MAX - GAP_MIN + 8'd1;

   // Playfield limits and bird footprint
   localparam logic [7:0]        X_RIGHT     = 8'(SCREEN_W - 1);
   localparam logic signed [8:0] Y_TOP       = 9'sd1;
   localparam logic signed [8:0] Y_FLOOR     = 9'(SCREEN_H - 2);
   localparam logic [7:0]        COL_LO      = BIRD_X - 8'd1;
   localparam logic [7:0]        COL_HI      = BIRD_X + 8'd1;

   // Values loaded on reset and on restart from DEAD
   localparam logic [6:0]        Y_INIT      = 7'd60;
   localparam logic [6:0]        PY_INIT     = 7'd48;
   localparam logic [7:0]        LFSR_SEED   = 8'hA5;

   // Score increment with saturation, in the build-selected encoding
   function automatic logic [7:0] score_inc(input logic [7:0] s);
      logic [7:0] r;
`ifdef SCORE_BCD_EN
      if (s == 8'h99) begin
         r = s;
      end else if (s[3:0] == 4'd9) begin
         r = {s[7:4] + 4'd1, 4'd0};
      end else begin
         r = {s[7:4], s[3:0] + 4'd1};
      end
`else
      r = (s == 8'hFF) ? s : s + 8'd1;
`endif
      return r;
   endfunction

endpackage

// File: rtl/flappy_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded with 8'hA5 on reset.
// Advances every cycle; output is the current register value.
// No backpressure; the shift is invertible so a non-zero seed never reaches zero.
module flappy_lfsr
   import flappy_pkg::*;
(
   input  logic       CLOCK_50,
   input  logic       reset,
   output logic [7:0] q
);

   logic [7:0] lfsr_q;
   logic [7:0] lfsr_d;

   // Shift left, feeding back the XOR of taps 8,6,5,4
   always_comb begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   // Seed register
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign q = lfsr_q;

endmodule

// File: rtl/game_state_updater.sv
// Flappy game-logic stage: bird/pipe physics, score and alive state; emits the per-frame erase request.
// Physics commits 2 cycles after the painter's erase-done toggle is sampled; game_pulse is registered.
// No backpressure; a flap edge waits in flap_pending until the next step. Score BCD via SCORE_BCD_EN.
module game_state_updater
   import flappy_pkg::*;
#(
   parameter int FRAME_DIV = 833333
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       flap,
   input  logic       game_tick_after_erase,
   output logic       game_pulse,
   output logic [6:0] box_y,
   output logic [7:0] pipe_one_x,
   output logic [6:0] pipe_one_y,
   output logic [7:0] score,
   output logic       dead
);

   localparam int               CNT_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

   logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic              game_pulse_q, game_pulse_d;
   logic              tick_q, tick_prev_q, step_q;
   logic              flap_prev_q;
   logic              flap_pending_q, flap_pending_d;
   game_state_t       state_q, state_d;
   logic signed [4:0] vel_q, vel_d;
   logic [6:0]        box_y_q, box_y_d;
   logic [7:0]        pipe_x_q, pipe_x_d;
   logic [6:0]        pipe_y_q, pipe_y_d;
   logic [7:0]        score_q, score_d;
   logic              dead_q, dead_d;

   logic              step;
   logic              flap_rise;
   logic              flap_eff;
   logic [7:0]        lfsr_q;

   // Candidate results of one physics step, used only when a step commits
   logic signed [4:0] vel_sum, vel_run;
   logic signed [8:0] y_sum;
   logic [6:0]        y_run;
   logic [7:0]        x_run;
   logic [6:0]        py_run;
   logic [6:0]        bird_top, bird_bot, gap_bot;
   logic              floor_hit, in_col, hit, cleared;

   flappy_lfsr u_lfsr (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .q        (lfsr_q)
   );

   // Frame counter wraps at FRAME_DIV-1; the pulse is registered against the next count
   always_comb begin
      frame_cnt_d  = (frame_cnt_q == CNT_LAST) ? '0 : frame_cnt_q + CNT_W'(1);
      game_pulse_d = (frame_cnt_d == CNT_LAST);
   end

   // Edge detection on the erase-done toggle and the flap button
   always_comb begin
      step      = tick_q ^ tick_prev_q;
      flap_rise = flap & ~flap_prev_q;
      flap_eff  = flap_pending_q | flap_rise;
   end

   // One physics step: velocity, vertical clamp, pipe scroll, collision and score
   always_comb begin
      vel_sum = vel_q + GRAVITY;
      if (flap_eff) begin
         vel_run = -FLAP_VEL;
      end else if (vel_sum > MAX_VEL) begin
         vel_run = MAX_VEL;
      end else if (vel_sum < -MAX_VEL) begin
         vel_run = -MAX_VEL;
      end else begin
         vel_run = vel_sum;
      end

      y_sum     = $signed({2'b00, box_y_q}) + 9'(vel_run);
      floor_hit = 1'b0;
      if (y_sum < Y_TOP) begin
         y_run = 7'(Y_TOP);
      end else if (y_sum > Y_FLOOR) begin
         y_run     = 7'(Y_FLOOR);
         floor_hit = 1'b1;
      end else begin
         y_run = y_sum[6:0];
      end

      if (pipe_x_q < PIPE_SPEED) begin
         x_run  = X_RIGHT;
         py_run = 7'(GAP_MIN + (lfsr_q % GAP_SPAN));
      end else begin
         x_run  = pipe_x_q - PIPE_SPEED;
         py_run = pipe_y_q;
      end

      // The bird spans rows y-1..y+1; any row outside the gap is a crash
      bird_top = y_run - 7'd1;
      bird_bot = y_run + 7'd1;
      gap_bot  = py_run + GAP_H - 7'd1;
      in_col   = (x_run >= COL_LO) && (x_run <= COL_HI);
      hit      = in_col && ((bird_top < py_run) || (bird_bot > gap_bot));
      cleared  = (pipe_x_q >= COL_LO) && (x_run < COL_LO) && !hit;
   end

   // Game FSM next state: IDLE waits for a flap, RUN steps physics, DEAD freezes until a flap
   always_comb begin
      state_d        = state_q;
      vel_d          = vel_q;
      box_y_d        = box_y_q;
      pipe_x_d       = pipe_x_q;
      pipe_y_d       = pipe_y_q;
      score_d        = score_q;
      flap_pending_d = flap_pending_q | flap_rise;

      case (state_q)
         IDLE, RUN: begin
            if (step_q && (state_q == RUN || flap_eff)) begin
               vel_d          = vel_run;
               box_y_d        = y_run;
               pipe_x_d       = x_run;
               pipe_y_d       = py_run;
               flap_pending_d = 1'b0;
               if (cleared) begin
                  score_d = score_inc(score_q);
               end
               state_d = (floor_hit || hit) ? DEAD : RUN;
            end
         end
         DEAD: begin
            flap_pending_d = 1'b0;
            if (flap_rise) begin
               state_d  = IDLE;
               vel_d    = '0;
               box_y_d  = Y_INIT;
               pipe_x_d = X_RIGHT;
               pipe_y_d = PY_INIT;
               score_d  = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      dead_d = (state_d == DEAD);
   end

   // All state registers; reset wins over any step in flight
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         frame_cnt_q    <= '0;
         game_pulse_q   <= 1'b0;
         tick_q         <= 1'b0;
         tick_prev_q    <= 1'b0;
         step_q         <= 1'b0;
         flap_prev_q    <= 1'b0;
         flap_pending_q <= 1'b0;
         state_q        <= IDLE;
         vel_q          <= '0;
         box_y_q        <= Y_INIT;
         pipe_x_q       <= X_RIGHT;
         pipe_y_q       <= PY_INIT;
         score_q        <= '0;
         dead_q         <= 1'b0;
      end else begin
         frame_cnt_q    <= frame_cnt_d;
         game_pulse_q   <= game_pulse_d;
         tick_q         <= game_tick_after_erase;
         tick_prev_q    <= tick_q;
         step_q         <= step;
         flap_prev_q    <= flap;
         flap_pending_q <= flap_pending_d;
         state_q        <= state_d;
         vel_q          <= vel_d;
         box_y_q        <= box_y_d;
         pipe_x_q       <= pipe_x_d;
         pipe_y_q       <= pipe_y_d;
         score_q        <= score_d;
         dead_q         <= dead_d;
      end
   end

   assign game_pulse = game_pulse_q;
   assign box_y      = box_y_q;
   assign pipe_one_x = pipe_x_q;
   assign pipe_one_y = pipe_y_q;
   assign score      = score_q;
   assign dead       = dead_q;

endmodule
